// File: rtl/tetris_bag_randomizer_pkg.sv
// -----------------------------------------------------------------------------
// tetris_bag_randomizer_pkg
// Shared definitions for the Tetris piece generator: the standard piece set,
// the piece-ID type used by the game build, and the LFSR constants and step
// helpers shared by the randomizer blocks.
// -----------------------------------------------------------------------------
package tetris_bag_randomizer_pkg;

    localparam int          NUM_PIECES_STD = 7;
    localparam int          PIECE_W_STD    = 3;
    localparam logic [15:0] LFSR_MASK      = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED   = 16'hACE1;

    typedef logic [PIECE_W_STD-1:0] piece_id_t;

    // One step of the 16-bit right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // An all-zero state would lock the LFSR, so substitute 1.
    function automatic logic [15:0] seed_guard(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/tetris_bag_randomizer_lfsr.sv
// -----------------------------------------------------------------------------
// bag_lfsr16
// Free-running 16-bit Galois LFSR for the bag randomizer. Steps every cycle;
// a reseed pulse loads a new seed instead of stepping. Zero seeds are replaced
// by 1.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (loads SEED)
//   reseed_i    load seed_i on this edge
//   seed_i      replacement seed
//   lfsr_o      current LFSR state (registered)
// -----------------------------------------------------------------------------
module bag_lfsr16
    import tetris_bag_randomizer_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reseed_i,
    input  logic [15:0] seed_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_r;

    // LFSR state: reset/reseed load, otherwise advance one step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= seed_guard(SEED);
        end else if (reseed_i) begin
            lfsr_r <= seed_guard(seed_i);
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign lfsr_o = lfsr_r;

endmodule

// File: rtl/tetris_bag_randomizer.sv
// -----------------------------------------------------------------------------
// tetris_bag_randomizer
// Bag-based piece generator: every NUM_PIECES consecutive draws contain each
// piece ID exactly once. Draws feed a shift-register preview queue popped by
// the game FSM with a valid/take handshake.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   reseed_i     load seed_i, clear the bag and flush the queue
//   seed_i       new LFSR seed
//   take_i       pop the head piece (ignored when the queue is empty)
//   piece_o      head piece ID, valid when valid_o=1
//   valid_o      queue non-empty
//   preview_o    queue slots, slot 0 in the LSBs; unfilled slots are 0
//   count_o      number of queued pieces
//   bag_wrap_o   one-cycle pulse when the queued draw completed a bag
// -----------------------------------------------------------------------------
module tetris_bag_randomizer
    import tetris_bag_randomizer_pkg::*;
#(
    parameter int          NUM_PIECES    = NUM_PIECES_STD,
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] SEED          = DEFAULT_SEED,
    localparam int         PIECE_W       = $clog2(NUM_PIECES),
    localparam int         CNT_W         = $clog2(PREVIEW_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               reseed_i,
    input  logic [15:0]                        seed_i,
    input  logic                               take_i,
    output logic [PIECE_W-1:0]                 piece_o,
    output logic                               valid_o,
    output logic [PREVIEW_DEPTH*PIECE_W-1:0]   preview_o,
    output logic [CNT_W-1:0]                   count_o,
    output logic                               bag_wrap_o
);

    localparam logic [NUM_PIECES-1:0] ID0_BIT   = {{(NUM_PIECES-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(PREVIEW_DEPTH);

    logic [15:0]               lfsr_s;
    logic                      lfsr_hi_unused_s;
    logic [NUM_PIECES-1:0]     mask_r;
    logic [NUM_PIECES-1:0]     mask_set_s;
    logic                      bag_full_s;
    logic [PIECE_W-1:0]        draw_s;
    logic [PIECE_W-1:0]        slot_r     [PREVIEW_DEPTH];
    logic [PIECE_W-1:0]        shift_s    [PREVIEW_DEPTH];
    logic [PIECE_W-1:0]        slot_nxt_s [PREVIEW_DEPTH];
    logic [PREVIEW_DEPTH*PIECE_W-1:0] preview_s;
    logic [CNT_W-1:0]          count_r;
    logic [CNT_W-1:0]          count_nxt_s;
    logic [CNT_W-1:0]          wr_idx_s;
    logic                      valid_r;
    logic                      wrap_r;
    logic                      hold_r;
    logic                      pop_s;
    logic                      push_s;

    bag_lfsr16 #(
        .SEED     (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .reseed_i (reseed_i),
        .seed_i   (seed_i),
        .lfsr_o   (lfsr_s)
    );

    // Only the low byte selects the scan start.
    assign lfsr_hi_unused_s = ^lfsr_s[15:8];

    // Draw: scan upward from lfsr[7:0] mod NUM_PIECES for the first undrawn ID.
    always_comb begin
        int   start_v;
        int   idx_v;
        logic found_v;
        start_v = 32'(lfsr_s[7:0]) % NUM_PIECES;
        found_v = 1'b0;
        draw_s  = '0;
        for (int k = 0; k < NUM_PIECES; k++) begin
            idx_v = (start_v + k) % NUM_PIECES;
            if (!found_v && !mask_r[idx_v[PIECE_W-1:0]]) begin
                found_v = 1'b1;
                draw_s  = idx_v[PIECE_W-1:0];
            end else begin
                found_v = found_v;
            end
        end
        mask_set_s = mask_r | (ID0_BIT << draw_s);
        bag_full_s = &mask_set_s;
    end

    // Handshake: pop only a non-empty queue; push whenever a slot is or becomes free.
    // The cycle after a reseed is held idle so refill begins one cycle later.
    always_comb begin
        pop_s       = take_i && (count_r != '0);
        push_s      = !hold_r && ((count_r != FULL_CNT) || take_i);
        count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        wr_idx_s    = count_r - CNT_W'(pop_s);
    end

    // Next queue contents: shift toward slot 0 on pop, append the draw at the tail.
    always_comb begin
        for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
            shift_s[i] = slot_r[i+1];
        end
        shift_s[PREVIEW_DEPTH-1] = '0;
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            slot_nxt_s[i] = (push_s && (CNT_W'(i) == wr_idx_s)) ? draw_s
                          : (pop_s ? shift_s[i] : slot_r[i]);
        end
    end

    // Registered state: queue, count, bag mask and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r  <= '{default: '0};
            count_r <= '0;
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
            hold_r  <= 1'b0;
            mask_r  <= '0;
        end else if (reseed_i) begin
            slot_r  <= '{default: '0};
            count_r <= '0;
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
            hold_r  <= 1'b1;
            mask_r  <= '0;
        end else begin
            slot_r  <= slot_nxt_s;
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
            wrap_r  <= push_s && bag_full_s;
            hold_r  <= 1'b0;
            if (push_s) begin
                mask_r <= bag_full_s ? '0 : mask_set_s;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Flatten the queue slots onto the preview bus, slot 0 in the LSBs.
    always_comb begin
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            preview_s[i*PIECE_W +: PIECE_W] = slot_r[i];
        end
    end

    assign piece_o    = slot_r[0];
    assign valid_o    = valid_r;
    assign preview_o  = preview_s;
    assign count_o    = count_r;
    assign bag_wrap_o = wrap_r;

endmodule
